// File: rtl/gen_mem_pkg.sv
// Shared definitions for the generated one-port memory family: state encoding,
// legal latency/mode values and a constant clog2 usable in parameter expressions.
package gen_mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    localparam int unsigned RD_LAT_MIN   = 1;
    localparam int unsigned RD_LAT_MAX   = 2;
    localparam int unsigned WR_MODE_KEEP = 0;
    localparam int unsigned WR_MODE_THRU = 1;

    // Never returns less than 1 so a single-word memory still has an address bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/one_port_mem_init_fsm.sv
// Post-reset initialisation sequencer: sweeps every word once, then parks in READY
// until the next reset.
module one_port_mem_init_fsm
    import gen_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned AW      = 11,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic          CLK,
    input  logic          RSTN,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    mem_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            if (INIT_EN) begin
                state_q <= ST_INIT;
            end else begin
                state_q <= ST_READY;
            end
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_addr = cnt_q;
    assign busy      = (state_q == ST_INIT);

endmodule

// File: rtl/param_one_port_mem.sv
// Parametrised single-port synchronous memory with byte mask, 1/2-cycle read
// latency, selectable read-during-write behaviour and post-reset initialisation.
module param_one_port_mem
    import gen_mem_pkg::*;
#(
    parameter int unsigned       DEPTH    = 2048,
    parameter int unsigned       WIDTH    = 8,
    parameter int unsigned       BYTE_W   = 8,
    parameter int unsigned       RD_LAT   = 1,
    parameter int unsigned       WR_MODE  = 0,
    parameter bit                INIT_EN  = 1'b1,
    parameter logic [WIDTH-1:0]  INIT_VAL = '0,
    localparam int unsigned      AW       = clog2(DEPTH),
    localparam int unsigned      NB       = WIDTH / BYTE_W
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [AW-1:0]    A,
    input  logic             CEN,
    input  logic             WEN,
    input  logic [NB-1:0]    BWEN,
    input  logic [WIDTH-1:0] D,
    input  logic             OEN,
    output wire  [WIDTH-1:0] Q,
    output logic             QVLD,
    output logic             BUSY
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             init_we;
    logic [AW-1:0]    init_addr;
    logic             busy;

    one_port_mem_init_fsm #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .INIT_EN (INIT_EN)
    ) u_init_fsm (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .init_we   (init_we),
        .init_addr (init_addr),
        .busy      (busy)
    );

    logic             acc;
    logic             in_range;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] merged;

    assign acc      = !busy && !CEN;
    assign in_range = (32'(A) < DEPTH);
    // Out-of-range reads (and the old half of an out-of-range merge) see zero.
    assign rd_word  = in_range ? mem[A] : '0;

    always_comb begin
        merged = rd_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (!BWEN[i]) begin
                merged[i*BYTE_W +: BYTE_W] = D[i*BYTE_W +: BYTE_W];
            end
        end
    end

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = A;
        mem_wdata = merged;
        if (init_we) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr;
            mem_wdata = INIT_VAL;
        end else if (acc && !WEN && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic             vld1_q, vld1_d;
    logic             vld2_q, vld2_d;

    always_comb begin
        rd1_d  = rd1_q;
        vld1_d = 1'b0;
        if (acc) begin
            if (WEN) begin
                rd1_d  = rd_word;
                vld1_d = 1'b1;
            end else if (WR_MODE == WR_MODE_THRU) begin
                rd1_d  = merged;
                vld1_d = 1'b1;
            end
        end
        rd2_d  = vld1_q ? rd1_q : rd2_q;
        vld2_d = vld1_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd1_q  <= '0;
            rd2_q  <= '0;
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
        end else begin
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            vld1_q <= vld1_d;
            vld2_q <= vld2_d;
        end
    end

    logic [WIDTH-1:0] q_data;

    assign q_data = (RD_LAT == 2) ? rd2_q : rd1_q;
    assign QVLD   = (RD_LAT == 2) ? vld2_q : vld1_q;
    assign BUSY   = busy;
    assign Q      = OEN ? {WIDTH{1'bz}} : q_data;

    always_ff @(posedge CLK) begin
        if (RSTN && acc && !in_range) begin
            $display("WARNING: %m out-of-range address %0d (DEPTH=%0d)", A, DEPTH);
        end
    end

    initial begin
        if ((WIDTH % BYTE_W) != 0 || RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX ||
            (WR_MODE != WR_MODE_KEEP && WR_MODE != WR_MODE_THRU)) begin
            $display("ERROR: %m bad parameters WIDTH=%0d BYTE_W=%0d RD_LAT=%0d WR_MODE=%0d",
                     WIDTH, BYTE_W, RD_LAT, WR_MODE);
            $finish;
        end
        $display("%m: param_one_port_mem DEPTH=%0d WIDTH=%0d BYTE_W=%0d RD_LAT=%0d WR_MODE=%0d",
                 DEPTH, WIDTH, BYTE_W, RD_LAT, WR_MODE);
    end

endmodule

// File: tb/tb_param_one_port_mem.sv
// Bench for param_one_port_mem: three configurations share one stimulus stream and
// are checked against a result-queue reference model plus directed sequences.
module tb_param_one_port_mem;

    logic        clk;
    logic        rstn;
    logic [10:0] a;
    logic        cen;
    logic        wen;
    logic [3:0]  bwen;
    logic [31:0] d;
    logic        oen;

    wire  [31:0] q1, q2, q3;
    logic        vld1, vld2, vld3;
    logic        busy1, busy2, busy3;

    // DUT1: RD_LAT=1, keep mode.  DUT2: RD_LAT=2, write-through.  DUT3: DEPTH=1000.
    param_one_port_mem #(
        .DEPTH(2048), .WIDTH(32), .BYTE_W(8), .RD_LAT(1), .WR_MODE(0),
        .INIT_EN(1'b1), .INIT_VAL(32'hA5A5A5A5)
    ) u_dut1 (
        .CLK(clk), .RSTN(rstn), .A(a), .CEN(cen), .WEN(wen), .BWEN(bwen), .D(d),
        .OEN(oen), .Q(q1), .QVLD(vld1), .BUSY(busy1)
    );

    param_one_port_mem #(
        .DEPTH(2048), .WIDTH(32), .BYTE_W(8), .RD_LAT(2), .WR_MODE(1),
        .INIT_EN(1'b1), .INIT_VAL(32'hA5A5A5A5)
    ) u_dut2 (
        .CLK(clk), .RSTN(rstn), .A(a), .CEN(cen), .WEN(wen), .BWEN(bwen), .D(d),
        .OEN(oen), .Q(q2), .QVLD(vld2), .BUSY(busy2)
    );

    param_one_port_mem #(
        .DEPTH(1000), .WIDTH(32), .BYTE_W(8), .RD_LAT(1), .WR_MODE(1),
        .INIT_EN(1'b1), .INIT_VAL(32'h0)
    ) u_dut3 (
        .CLK(clk), .RSTN(rstn), .A(a[9:0]), .CEN(cen), .WEN(wen), .BWEN(bwen), .D(d),
        .OEN(oen), .Q(q3), .QVLD(vld3), .BUSY(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: per-configuration array, init countdown and a queue of read
    // results stamped with the edge at which they become visible on Q.
    typedef struct {
        int          dut;
        logic [31:0] val;
        int          due;
    } res_t;

    int unsigned cfg_depth [3] = '{2048, 2048, 1000};
    int          cfg_lat   [3] = '{1, 2, 1};
    int          cfg_wm    [3] = '{0, 1, 1};
    logic [31:0] cfg_iv    [3] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0};

    logic [31:0] mm [3][2048];
    int          busy_left [3];
    int          init_idx  [3];
    logic [31:0] held      [3];
    logic        evld      [3];
    res_t        pq [$];
    int          edge_n = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            busy_left[k] = int'(cfg_depth[k]);
            init_idx[k]  = 0;
            held[k]      = 32'h0;
            evld[k]      = 1'b0;
        end
        pq.delete();
    endtask

    task automatic model_edge();
        int unsigned addr;
        logic [31:0] old;
        logic [31:0] nw;
        res_t        r;
        edge_n++;
        if (!rstn) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            evld[k] = 1'b0;
            addr = (k == 2) ? int'(a[9:0]) : int'(a);
            if (busy_left[k] > 0) begin
                mm[k][init_idx[k]] = cfg_iv[k];
                init_idx[k]++;
                busy_left[k]--;
            end else if (!cen) begin
                old = (addr < cfg_depth[k]) ? mm[k][addr] : 32'h0;
                if (wen) begin
                    r = '{dut: k, val: old, due: edge_n + cfg_lat[k] - 1};
                    pq.push_back(r);
                end else begin
                    nw = old;
                    for (int b = 0; b < 4; b++) begin
                        if (!bwen[b]) nw[b*8 +: 8] = d[b*8 +: 8];
                    end
                    if (addr < cfg_depth[k]) mm[k][addr] = nw;
                    if (cfg_wm[k] == 1) begin
                        r = '{dut: k, val: nw, due: edge_n + cfg_lat[k] - 1};
                        pq.push_back(r);
                    end
                end
            end
        end
        for (int i = pq.size() - 1; i >= 0; i--) begin
            if (pq[i].due == edge_n) begin
                held[pq[i].dut] = pq[i].val;
                evld[pq[i].dut] = 1'b1;
                pq.delete(i);
            end
        end
    endtask

    function automatic logic [31:0] get_q(int k);
        return (k == 0) ? q1 : (k == 1) ? q2 : q3;
    endfunction

    function automatic logic get_vld(int k);
        return (k == 0) ? vld1 : (k == 1) ? vld2 : vld3;
    endfunction

    function automatic logic get_busy(int k);
        return (k == 0) ? busy1 : (k == 1) ? busy2 : busy3;
    endfunction

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model busy dut%0d e%0d", k + 1, edge_n),
                32'(get_busy(k)), 32'(busy_left[k] > 0));
            chk($sformatf("model qvld dut%0d e%0d", k + 1, edge_n),
                32'(get_vld(k)), 32'(evld[k]));
            if (!oen) begin
                chk($sformatf("model q dut%0d e%0d", k + 1, edge_n), get_q(k), held[k]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic c, input logic w, input logic [10:0] aa,
                         input logic [3:0] bw, input logic [31:0] dd);
        cen  = c;
        wen  = w;
        a    = aa;
        bwen = bw;
        d    = dd;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 11'd0, 4'hF, 32'h0);
    endtask

    task automatic async_reset_check(input string tag);
        rstn = 1'b0;
        model_reset();
        #1;
        chk({tag, " q1"}, q1, 32'h0);
        chk({tag, " q2"}, q2, 32'h0);
        chk({tag, " q3"}, q3, 32'h0);
        chk({tag, " vld"}, {29'b0, vld1, vld2, vld3}, 32'h0);
        chk({tag, " busy"}, {29'b0, busy1, busy2, busy3}, 32'h7);
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (busy1 && n < 3000) begin
            step();
            n++;
        end
        chk({tag, " busy cycles"}, 32'(n), 32'd2048);
    endtask

    typedef struct {
        logic        cen;
        logic        wen;
        logic [10:0] a;
        logic [3:0]  bwen;
        logic [31:0] d;
        logic        chk_q;
        logic [31:0] exp_q;
        logic        exp_vld;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int vcnt;

        tbl[0] = '{1'b0, 1'b0, 11'd5, 4'b0000, 32'h11223344, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 1'b0, 11'd5, 4'b1010, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b0};
        tbl[2] = '{1'b0, 1'b1, 11'd5, 4'b0000, 32'h0,        1'b1, 32'h11FF33FF, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 11'd7, 4'b0000, 32'hCAFEF00D, 1'b1, 32'h11FF33FF, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 11'd7, 4'b0000, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 11'd7, 4'b0000, 32'h12345678, 1'b1, 32'hCAFEF00D, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 11'd7, 4'b1111, 32'h0,        1'b1, 32'h12345678, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 11'd9, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 11'd9, 4'b0000, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 11'd0, 4'b1111, 32'h0,        1'b1, 32'hA5A5A5A5, 1'b0};

        rstn = 1'b0;
        oen  = 1'b0;
        idle();
        model_reset();
        repeat (2) step();
        chk("reset q1", q1, 32'h0);
        chk("reset busy1", 32'(busy1), 32'd1);

        rstn = 1'b1;
        count_busy("init");

        // Spot reads after init, including the last word.
        drive(1'b0, 1'b1, 11'd0, 4'h0, 32'h0);
        step();
        chk("init rd0 q", q1, 32'hA5A5A5A5);
        chk("init rd0 vld", 32'(vld1), 32'd1);
        drive(1'b0, 1'b1, 11'd1023, 4'h0, 32'h0);
        step();
        chk("init rd1023 q", q1, 32'hA5A5A5A5);
        drive(1'b0, 1'b1, 11'd2047, 4'h0, 32'h0);
        step();
        chk("init rd2047 q", q1, 32'hA5A5A5A5);
        chk("init rd2047 vld", 32'(vld1), 32'd1);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].cen, tbl[i].wen, tbl[i].a, tbl[i].bwen, tbl[i].d);
            step();
            if (tbl[i].chk_q) chk($sformatf("tbl%0d q", i), q1, tbl[i].exp_q);
            chk($sformatf("tbl%0d vld", i), 32'(vld1), 32'(tbl[i].exp_vld));
        end

        // Write-through on DUT3.
        drive(1'b0, 1'b0, 11'd7, 4'b0000, 32'hCAFEF00D);
        step();
        drive(1'b0, 1'b1, 11'd7, 4'b0000, 32'h0);
        step();
        chk("thru rd q3", q3, 32'hCAFEF00D);
        drive(1'b0, 1'b0, 11'd7, 4'b0000, 32'h12345678);
        step();
        chk("thru wr q3", q3, 32'h12345678);
        chk("thru wr vld3", 32'(vld3), 32'd1);

        // Two-cycle latency back-to-back reads on DUT2.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b0, 11'(i), 4'b0000, 32'(i));
            step();
        end
        idle();
        repeat (3) step();
        vcnt = 0;
        drive(1'b0, 1'b1, 11'd1, 4'h0, 32'h0);
        step();
        chk("lat2 e1 vld", 32'(vld2), 32'd0);
        drive(1'b0, 1'b1, 11'd2, 4'h0, 32'h0);
        step();
        chk("lat2 e2 q", q2, 32'd1);
        vcnt += int'(vld2);
        drive(1'b0, 1'b1, 11'd3, 4'h0, 32'h0);
        step();
        chk("lat2 e3 q", q2, 32'd2);
        vcnt += int'(vld2);
        idle();
        step();
        chk("lat2 e4 q", q2, 32'd3);
        vcnt += int'(vld2);
        step();
        chk("lat2 e5 vld", 32'(vld2), 32'd0);
        chk("lat2 e5 q hold", q2, 32'd3);
        chk("lat2 vld count", 32'(vcnt), 32'd3);

        // Output enable: QVLD still strobes, Q released, data reappears when enabled.
        oen = 1'b1;
        drive(1'b0, 1'b1, 11'd5, 4'h0, 32'h0);
        step();
        chk("oen vld1", 32'(vld1), 32'd1);
        checks++;
        if (q1 === 32'h11FF33FF) begin
            errors++;
            $display("FAIL oen q1 driven: got %h required high-impedance", q1);
        end
        idle();
        oen = 1'b0;
        #1;
        chk("oen drop q1", q1, 32'h11FF33FF);
        step();

        // Out-of-range access on DEPTH=1000.
        drive(1'b0, 1'b0, 11'd1000, 4'b0000, 32'h77777777);
        step();
        drive(1'b0, 1'b1, 11'd1000, 4'h0, 32'h0);
        step();
        chk("oor rd q3", q3, 32'h0);
        chk("oor rd vld3", 32'(vld3), 32'd1);
        idle();
        step();

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
                  11'($urandom_range(0, 999)), 4'($urandom), $urandom);
            oen = ($urandom_range(0, 9) == 0);
            step();
        end
        oen = 1'b0;

        // Async reset while data is valid, then a reset in the middle of init.
        drive(1'b0, 1'b1, 11'd2047, 4'h0, 32'h0);
        step();
        chk("pre-rst q1", q1, 32'hA5A5A5A5);
        chk("pre-rst vld1", 32'(vld1), 32'd1);
        idle();
        async_reset_check("rst1");
        step();
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 11'($urandom_range(0, 999)), 4'h0, 32'h0);
            step();
        end
        async_reset_check("rst2");
        step();
        rstn = 1'b1;
        count_busy("reinit");
        idle();
        step();
        drive(1'b0, 1'b1, 11'd5, 4'h0, 32'h0);
        step();
        chk("reinit rd5 q1", q1, 32'hA5A5A5A5);
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_one_port_mem.md
Name: param_one_port_mem

Overview:
- Parametrised single-port synchronous memory model; successor to the fixed-size one-port vendor memory models in the memory generator library.
- Adds over the fixed-size models:
  - configurable depth and width;
  - active-low byte write mask;
  - 1- or 2-cycle read latency with a read-valid strobe;
  - selectable read-during-write mode;
  - post-reset memory initialisation sequencer with BUSY flag.
- Instantiated by generated wrappers wherever a one-port memory of arbitrary geometry is needed.

Parameters:
- DEPTH, 2048: number of words; need not be a power of two.
- WIDTH, 8: data word width in bits.
- BYTE_W, 8: write-mask granularity; WIDTH must be a multiple of BYTE_W.
- RD_LAT, 1: read latency in cycles, 1 or 2.
- WR_MODE, 0: read-during-write behaviour. 0 = Q unchanged; 1 = write-through.
- INIT_EN, 1: 1 = clear memory after reset; 0 = skip initialisation.
- INIT_VAL, 0: WIDTH-bit value written to every word during initialisation.
- Derived: AW = clog2(DEPTH), NB = WIDTH/BYTE_W.

Ports:
- CLK   input  1      clock, all state on rising edge
- RSTN  input  1      asynchronous active-low reset
- A     input  AW     word address
- CEN   input  1      chip enable, active low
- WEN   input  1      write enable, active low; 1 = read
- BWEN  input  NB     per-byte write enable, active low; ignored on reads
- D     input  WIDTH  write data
- OEN   input  1      output enable, active low
- Q     output WIDTH  read data; high-impedance when OEN=1
- QVLD  output 1      Q carries new read data this cycle
- BUSY  output 1      initialisation in progress; accesses ignored

Behaviour:
- Interface: one clock (CLK); reset RSTN is asynchronous and active-low.
- Reset (RSTN=0), applied immediately and asynchronously:
  - read data registers = 0, QVLD = 0, init counter = 0;
  - state = INIT if INIT_EN=1, else READY;
  - BUSY = 1 if INIT_EN=1, else 0;
  - memory array contents are not reset.
- FSM states:
  - INIT: each cycle writes INIT_VAL to mem[cnt], cnt++. When cnt = DEPTH-1 is written, go to READY on that edge. INIT lasts exactly DEPTH cycles after the first rising edge with RSTN=1.
  - READY: normal access. No exit except reset.
  - Reset asserted mid-INIT: counter returns to 0 and initialisation restarts from word 0.
- BUSY = (state == INIT). While BUSY, CEN/WEN/BWEN/A/D are ignored, no reads occur and QVLD stays 0.
- Write (READY, CEN=0, WEN=0): for each byte i with BWEN[i]=0, mem[A] byte i <= D byte i; other bytes are retained.
  - All BWEN=1: no change, but the access still counts as a write for WR_MODE.
- Read (READY, CEN=0, WEN=1): stage-1 register <= mem[A] at the access edge.
- Read-during-write:
  - WR_MODE=0: stage-1 register holds its value; no QVLD strobe.
  - WR_MODE=1: stage-1 register <= merged word (old bytes plus written bytes) and a QVLD strobe is produced.
- Idle (CEN=1): no array change; read registers hold their values.
- Latency and QVLD:
  - RD_LAT=1: Q = stage-1 register. QVLD is high for the one cycle following the access edge.
  - RD_LAT=2: stage-2 register <= stage-1 register on the edge after a read, then holds. Q = stage-2 register. QVLD is high exactly one cycle later than with RD_LAT=1.
  - Back-to-back reads give one result per cycle with QVLD continuously high.
- OEN is combinational on Q only (Q = OEN ? 'z : data). It does not affect QVLD or internal registers.
- Out-of-range address (A >= DEPTH):
  - writes are dropped;
  - reads load 0 and still strobe QVLD;
  - a $display warning with %m and the address is issued.
- Elaboration checks:
  - WIDTH % BYTE_W != 0 or RD_LAT not in {1,2} gives a $display error followed by $finish.
  - An initial $display announces the instance and its geometry.

Decomposition:
- Package gen_mem_pkg:
  - state encoding constants ST_INIT, ST_READY;
  - RD_LAT_MIN/RD_LAT_MAX;
  - WR_MODE_KEEP=0, WR_MODE_THRU=1;
  - the clog2 function.
- Sub-module one_port_mem_init_fsm holds the state, counter and BUSY logic. It outputs init_we, init_addr and busy, and the top level multiplexes these onto the array write port.
- Byte-merge, read pipeline and tristate stay in the top level.

Test Plan (DEPTH=2048, WIDTH=32, BYTE_W=8, RD_LAT=1 unless stated):
1. Release reset, INIT_EN=1, INIT_VAL=32'hA5A5A5A5 -> BUSY=1 for exactly 2048 cycles then 0. Reads of addresses 0, 1023 and 2047 return A5A5A5A5 with QVLD one cycle after each read edge.
2. Write A=5, D=32'h11223344, BWEN=4'b0000; then write A=5, D=32'hFFFFFFFF, BWEN=4'b1010; then read A=5 -> Q=32'h11FF33FF.
3. RD_LAT=2: reads of A=1,2,3 back-to-back (after writing 1,2,3) -> Q=1,2,3 on consecutive cycles starting 2 cycles after the first edge, with QVLD high for exactly 3 cycles.
4. Read A=7 gives 0xCAFEF00D, then a write A=7, D=0x12345678 with WR_MODE=0 -> Q stays 0xCAFEF00D and QVLD=0. The same sequence with WR_MODE=1 -> Q=0x12345678 and QVLD=1.
5. Assert RSTN at INIT cycle 100 and release -> Q=0 and QVLD=0 immediately, and BUSY lasts a full 2048 cycles from release. Read-during-INIT requests are ignored.
6. OEN=1 during a read -> Q='z while QVLD still pulses. Dropping OEN shows the held data. Separately, DEPTH=1000 with a write then read at A=1000 -> read returns 0 and a warning is printed.
